pwr_event_counter: RTL

//  Receiving end of the gate power-count path. Each gate cell (buffer, and, or,
//  ff ...) drives one EVT line. This block counts rising edges per line and

---
 rtl/pwr_event_counter.sv | 105 ++++++++++
 1 files changed

// File: rtl/pwr_event_counter.sv
// pwr_event_counter: per-channel rising-edge counters for gate EVT lines,
// read out through a four-phase RD_REQ/RD_ACK handshake.
module pwr_event_counter #(
    parameter int NCH  = 4,
    parameter int CW   = 16,
    parameter int SELW = 2
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            ENB,
    input  logic            CLR,
    input  logic [NCH-1:0]  EVT,
    input  logic            RD_REQ,
    input  logic [SELW-1:0] RD_SEL,
    output logic            RD_ACK,
    output logic [CW-1:0]   RD_DATA,
    output logic [NCH-1:0]  OVF
);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    logic [NCH-1:0] s1, s2, s3;
    logic [NCH-1:0] rise;
    logic [CW-1:0]  cnt [NCH];
    logic [CW-1:0]  rd_mux;
    state_t         state, state_nxt;
    logic           capture;

    // Two-flop synchroniser plus history flop; history tracks even when ENB=0
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= EVT;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Saturating counters; OVF marks an edge that arrived while already at max
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
            OVF <= '0;
        end else if (CLR) begin
            for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
            OVF <= '0;
        end else if (ENB) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (rise[i]) begin
                    if (cnt[i] == '1) OVF[i] <= 1'b1;
                    else              cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Channel select; out-of-range selects read as zero
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (RD_SEL == SELW'(i)) rd_mux = cnt[i];
        end
    end

    // Read FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Read FSM next state and capture strobe
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (RD_REQ) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!RD_REQ) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Captured read data; held between reads, cleared only by RESET
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        RD_DATA <= '0;
        else if (capture) RD_DATA <= rd_mux;
    end

    assign RD_ACK = (state == ACK);

endmodule
